// File: rtl/mem_arbiter_if.sv
// Bundles the icache, dcache and line-RAM signals seen by the memory arbiter.
// The arbiter takes the slave view; the cache/RAM environment takes the master view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 26,
   parameter int LINE_W = 128
);
   logic              ic_req;
   logic [ADDR_W-1:0] ic_addr;
   logic              ic_ready;
   logic [LINE_W-1:0] ic_rdata;
   logic              dc_req;
   logic              dc_we;
   logic [ADDR_W-1:0] dc_addr;
   logic [LINE_W-1:0] dc_wdata;
   logic              dc_ready;
   logic [LINE_W-1:0] dc_rdata;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [LINE_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_we;

   modport slave (
      input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
      output ic_ready, ic_rdata, dc_ready, dc_rdata,
             mem_rd_addr, mem_wr_addr, mem_wdata, mem_we
   );

   modport master (
      output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
      input  ic_ready, ic_rdata, dc_ready, dc_rdata,
             mem_rd_addr, mem_wr_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache refills and dcache refills/writebacks onto a single-port line RAM,
// modelling a fixed access latency and answering the winner with a one-cycle ready pulse.
module mem_arbiter #(
   parameter int ADDR_W  = 26,
   parameter int LINE_W  = 128,
   parameter int LATENCY = 5
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic {GRANT_IC = 1'b0, GRANT_DC = 1'b1} grant_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t            state;
   grant_t            last_grant;
   grant_t            winner;
   grant_t            grant_sel;
   logic [3:0]        cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [LINE_W-1:0] lat_wdata;
   logic              grant_we;
   logic [ADDR_W-1:0] grant_addr;
   logic              ic_ready_q;
   logic              dc_ready_q;
   logic              mem_we_q;
   logic [LINE_W-1:0] ic_rdata_q;
   logic [LINE_W-1:0] dc_rdata_q;

   // On a tie the requester that did not win last time gets the port.
   always_comb begin
      grant_sel = GRANT_IC;
      if (bus.ic_req && bus.dc_req)
         grant_sel = (last_grant == GRANT_IC) ? GRANT_DC : GRANT_IC;
      else if (bus.dc_req)
         grant_sel = GRANT_DC;
   end

   assign grant_we   = (grant_sel == GRANT_DC) && bus.dc_we;
   assign grant_addr = (grant_sel == GRANT_DC) ? bus.dc_addr : bus.ic_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         last_grant <= GRANT_IC;
         winner     <= GRANT_IC;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         mem_we_q   <= 1'b0;
         ic_ready_q <= 1'b0;
         dc_ready_q <= 1'b0;
         ic_rdata_q <= '0;
         dc_rdata_q <= '0;
      end else begin
         ic_ready_q <= 1'b0;
         dc_ready_q <= 1'b0;
         mem_we_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.ic_req || bus.dc_req) begin
                  winner     <= grant_sel;
                  last_grant <= grant_sel;
                  lat_we     <= grant_we;
                  lat_addr   <= grant_addr;
                  lat_wdata  <= (grant_sel == GRANT_DC) ? bus.dc_wdata : '0;
                  cnt        <= CNT_INIT;
                  // A single-cycle access writes in the very first BUSY cycle.
                  mem_we_q   <= (LATENCY == 1) && grant_we;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  if (!lat_we) begin
                     if (winner == GRANT_IC)
                        ic_rdata_q <= bus.mem_rdata;
                     else
                        dc_rdata_q <= bus.mem_rdata;
                  end
                  ic_ready_q <= (winner == GRANT_IC);
                  dc_ready_q <= (winner == GRANT_DC);
                  state      <= RESP;
               end else begin
                  cnt      <= cnt - 4'd1;
                  // mem_we is registered, so it is raised one cycle ahead of cnt reaching zero.
                  mem_we_q <= lat_we && (cnt == 4'd1);
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ic_ready    = ic_ready_q;
   assign bus.dc_ready    = dc_ready_q;
   assign bus.ic_rdata    = ic_rdata_q;
   assign bus.dc_rdata    = dc_rdata_q;
   assign bus.mem_rd_addr = lat_addr;
   assign bus.mem_wr_addr = lat_addr;
   assign bus.mem_wdata   = lat_wdata;
   assign bus.mem_we      = mem_we_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a directed transaction table, hand-written corner
// sequences, and a randomized run against a transaction-level model of arbitration and RAM.
module tb_mem_arbiter;
   localparam int ADDR_W = 26;
   localparam int LINE_W = 128;
   localparam int LAT    = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ramFill = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();
   mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) busFast ();

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LATENCY(1)) dutFast (
      .clk(clk), .reset(reset), .bus(busFast)
   );

   function automatic logic [LINE_W-1:0] pattern(input logic [7:0] idx);
      return {4{24'hC0DE00, idx}};
   endfunction

   // Line RAM seen by the main instance: combinational read, write on the clock edge.
   logic [LINE_W-1:0] ram [256];
   always @(posedge clk) begin
      if (ramFill) begin
         for (int i = 0; i < 256; i++) ram[i] <= pattern(8'(i));
      end else if (bus.mem_we) begin
         ram[bus.mem_wr_addr[7:0]] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata     = ram[bus.mem_rd_addr[7:0]];
   assign busFast.mem_rdata = pattern(busFast.mem_rd_addr[7:0]);

   logic [LINE_W-1:0] modelRam [256];

   typedef struct {
      bit                isDc;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      logic [LINE_W-1:0] expData;
      logic [LINE_W-1:0] expOther;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                              input logic [LINE_W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkInt(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic idleInputs();
      bus.ic_req = 1'b0; bus.ic_addr = '0;
      bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
      busFast.ic_req = 1'b0; busFast.ic_addr = '0;
      busFast.dc_req = 1'b0; busFast.dc_we = 1'b0; busFast.dc_addr = '0; busFast.dc_wdata = '0;
   endtask

   task automatic resetDut();
      idleInputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic fillRam();
      ramFill = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ramFill = 1'b0;
      for (int i = 0; i < 256; i++) modelRam[i] = pattern(8'(i));
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.ic_req   = !v.isDc;
      bus.ic_addr  = v.addr;
      bus.dc_req   = v.isDc;
      bus.dc_we    = v.we;
      bus.dc_addr  = v.addr;
      bus.dc_wdata = v.wdata;
   endtask

   // Waits for the chosen requester's ready pulse, logging mem_we activity on the way.
   task automatic runTxn(input bit isDc, output int readyCycle, output int weCount,
                         output int weCycle, output logic [ADDR_W-1:0] weAddr,
                         output int wrongReady);
      readyCycle = -1; weCount = 0; weCycle = -1; weAddr = '0; wrongReady = 0;
      for (int n = 1; n <= 40 && readyCycle < 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.mem_we) begin
            weCount++; weCycle = n; weAddr = bus.mem_wr_addr;
         end
         if (isDc ? bus.ic_ready : bus.dc_ready) wrongReady++;
         if (isDc ? bus.dc_ready : bus.ic_ready) readyCycle = n;
      end
      bus.ic_req = 1'b0;
      bus.dc_req = 1'b0;
   endtask

   initial begin
      int readyCycle, weCount, weCycle, wrongReady, icAt, dcAt, pulses, lastAt, seen;
      logic [ADDR_W-1:0] weAddr;
      logic [LINE_W-1:0] a5, x5a, ff;
      a5  = {16{8'hA5}};
      x5a = {16{8'h5A}};
      ff  = {LINE_W{1'b1}};

      vecs[0] = '{1'b0, 1'b0, 26'h0,  '0,  pattern(8'h00), '0};
      vecs[1] = '{1'b1, 1'b1, 26'h10, a5,  '0,             pattern(8'h00)};
      vecs[2] = '{1'b1, 1'b0, 26'h10, '0,  a5,             pattern(8'h00)};
      vecs[3] = '{1'b0, 1'b0, 26'h10, '0,  a5,             a5};
      vecs[4] = '{1'b1, 1'b0, 26'h3,  '0,  pattern(8'h03), a5};
      vecs[5] = '{1'b1, 1'b1, 26'h3,  x5a, pattern(8'h03), a5};
      vecs[6] = '{1'b0, 1'b0, 26'h3,  '0,  x5a,            pattern(8'h03)};

      resetDut();
      checkOutput("reset ic_ready", bus.ic_ready, '0);
      checkOutput("reset dc_ready", bus.dc_ready, '0);
      checkOutput("reset mem_we", bus.mem_we, '0);
      checkOutput("reset mem_rd_addr", bus.mem_rd_addr, '0);
      checkOutput("reset mem_wr_addr", bus.mem_wr_addr, '0);
      checkOutput("reset mem_wdata", bus.mem_wdata, '0);
      checkOutput("reset ic_rdata", bus.ic_rdata, '0);
      checkOutput("reset dc_rdata", bus.dc_rdata, '0);
      fillRam();

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
         runTxn(vecs[i].isDc, readyCycle, weCount, weCycle, weAddr, wrongReady);
         checkInt($sformatf("vec%0d ready cycle", i), readyCycle, LAT + 1);
         checkInt($sformatf("vec%0d other ready", i), wrongReady, 0);
         checkInt($sformatf("vec%0d mem_we count", i), weCount, vecs[i].we ? 1 : 0);
         if (vecs[i].we) begin
            checkInt($sformatf("vec%0d mem_we cycle", i), weCycle, LAT);
            checkOutput($sformatf("vec%0d mem_wr_addr", i), weAddr, vecs[i].addr);
         end
         checkOutput($sformatf("vec%0d winner rdata", i),
                     vecs[i].isDc ? bus.dc_rdata : bus.ic_rdata, vecs[i].expData);
         checkOutput($sformatf("vec%0d loser rdata", i),
                     vecs[i].isDc ? bus.ic_rdata : bus.dc_rdata, vecs[i].expOther);
         @(posedge clk);
         @(negedge clk);
      end

      // Simultaneous requests from reset: DC first, IC right after, then DC again on the next tie.
      resetDut();
      bus.ic_req = 1'b1; bus.ic_addr = 26'h1;
      bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 26'h2;
      icAt = -1; dcAt = -1;
      for (int n = 1; n <= 40 && icAt < 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.dc_ready && bus.ic_ready) checkInt("tie both ready", 1, 0);
         if (bus.dc_ready) begin dcAt = n; bus.dc_req = 1'b0; end
         if (bus.ic_ready) begin icAt = n; bus.ic_req = 1'b0; end
      end
      checkInt("tie dc ready cycle", dcAt, LAT + 1);
      checkInt("tie ic ready cycle", icAt, 2 * LAT + 3);
      checkOutput("tie dc rdata", bus.dc_rdata, pattern(8'h02));
      checkOutput("tie ic rdata", bus.ic_rdata, pattern(8'h01));
      @(posedge clk);
      @(negedge clk);
      bus.ic_req = 1'b1; bus.ic_addr = 26'h5;
      bus.dc_req = 1'b1; bus.dc_addr = 26'h4;
      dcAt = -1; icAt = -1;
      for (int n = 1; n <= 40 && icAt < 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.dc_ready) begin dcAt = n; bus.dc_req = 1'b0; end
         if (bus.ic_ready) begin icAt = n; bus.ic_req = 1'b0; end
      end
      checkInt("tie2 dc ready cycle", dcAt, LAT + 1);
      checkInt("tie2 ic ready cycle", icAt, 2 * LAT + 3);
      @(posedge clk);
      @(negedge clk);

      // Reset landing in the middle of a writeback must leave no trace.
      bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 26'h20; bus.dc_wdata = ff;
      seen = 0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         seen += int'(bus.mem_we) + int'(bus.dc_ready) + int'(bus.ic_ready);
      end
      reset = 1'b1;
      bus.dc_req = 1'b0; bus.dc_we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort dc_ready", bus.dc_ready, '0);
      checkOutput("abort mem_we", bus.mem_we, '0);
      checkOutput("abort mem_wr_addr", bus.mem_wr_addr, '0);
      checkOutput("abort mem_wdata", bus.mem_wdata, '0);
      checkOutput("abort dc_rdata", bus.dc_rdata, '0);
      reset = 1'b0;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         seen += int'(bus.mem_we) + int'(bus.dc_ready) + int'(bus.ic_ready);
      end
      checkInt("abort activity", seen, 0);
      bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 26'h20;
      runTxn(1'b1, readyCycle, weCount, weCycle, weAddr, wrongReady);
      checkInt("abort reread ready", readyCycle, LAT + 1);
      checkOutput("abort line unchanged", bus.dc_rdata, pattern(8'h20));
      @(posedge clk);
      @(negedge clk);

      // Address wiggled while BUSY: the latched address must be the one used.
      bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 26'h6;
      readyCycle = -1;
      for (int n = 1; n <= 40 && readyCycle < 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 2) bus.dc_addr = 26'h7;
         if (n == LAT) checkOutput("hold mem_rd_addr", bus.mem_rd_addr, 26'h6);
         if (bus.dc_ready) readyCycle = n;
      end
      bus.dc_req = 1'b0;
      checkInt("hold ready cycle", readyCycle, LAT + 1);
      checkOutput("hold dc_rdata", bus.dc_rdata, pattern(8'h06));
      @(posedge clk);
      @(negedge clk);

      // Single-cycle latency instance: back-to-back IC reads answer every 3 cycles.
      busFast.ic_req = 1'b1; busFast.ic_addr = 26'h0;
      pulses = 0; lastAt = 0; seen = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk);
         @(negedge clk);
         seen += int'(busFast.dc_ready) + int'(busFast.mem_we);
         if (busFast.ic_ready) begin
            pulses++;
            checkInt("fast ready gap", n - lastAt, (pulses == 1) ? 2 : 3);
            checkOutput("fast ic_rdata", busFast.ic_rdata, pattern(busFast.ic_addr[7:0]));
            lastAt = n;
            busFast.ic_addr = busFast.ic_addr + 26'd1;
         end
      end
      busFast.ic_req = 1'b0;
      checkInt("fast pulse count", pulses, 10);
      checkInt("fast stray activity", seen, 0);
      checkOutput("fast dc_rdata", busFast.dc_rdata, '0);

      runRandom();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   task automatic newIc();
      bus.ic_req  = 1'b1;
      bus.ic_addr = {18'($urandom), 8'($urandom_range(0, 15))};
   endtask

   task automatic newDc();
      bus.dc_req   = 1'b1;
      bus.dc_we    = 1'($urandom_range(0, 1));
      bus.dc_addr  = {18'($urandom), 8'($urandom_range(0, 15))};
      bus.dc_wdata = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Transaction-level model: a grant at cycle g completes with mem_we at g+LAT and
   // ready at g+LAT+1; the port is free again at g+LAT+2.
   task automatic runRandom();
      bit                mBusy, mWho, mWe, mLastDc, eIcR, eDcR, eWe;
      int                mG;
      logic [ADDR_W-1:0] mAddr;
      logic [LINE_W-1:0] mWdata, mData, expIc, expDc;
      resetDut();
      fillRam();
      mBusy = 1'b0; mLastDc = 1'b0; mWho = 1'b0; mWe = 1'b0; mG = 0;
      mAddr = '0; mWdata = '0; mData = '0; expIc = '0; expDc = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         eIcR = mBusy && !mWho && (cyc == mG + LAT + 1);
         eDcR = mBusy &&  mWho && (cyc == mG + LAT + 1);
         eWe  = mBusy &&  mWe  && (cyc == mG + LAT);
         if (eIcR) expIc = mData;
         if (eDcR && !mWe) expDc = mData;
         checkOutput("rnd ic_ready", bus.ic_ready, eIcR);
         checkOutput("rnd dc_ready", bus.dc_ready, eDcR);
         checkOutput("rnd mem_we", bus.mem_we, eWe);
         checkOutput("rnd ic_rdata", bus.ic_rdata, expIc);
         checkOutput("rnd dc_rdata", bus.dc_rdata, expDc);
         if (mBusy && cyc == mG + LAT) begin
            if (mWe) begin
               checkOutput("rnd mem_wr_addr", bus.mem_wr_addr, mAddr);
               checkOutput("rnd mem_wdata", bus.mem_wdata, mWdata);
            end else begin
               checkOutput("rnd mem_rd_addr", bus.mem_rd_addr, mAddr);
            end
         end
         if (eIcR) begin
            if ($urandom_range(0, 1) == 1) newIc(); else bus.ic_req = 1'b0;
         end else if (!bus.ic_req && $urandom_range(0, 3) == 0) newIc();
         if (eDcR) begin
            if ($urandom_range(0, 1) == 1) newDc(); else bus.dc_req = 1'b0;
         end else if (!bus.dc_req && $urandom_range(0, 3) == 0) newDc();
         if (mBusy && cyc == mG + LAT + 1) begin
            mBusy = 1'b0;
         end else if (!mBusy && (bus.ic_req || bus.dc_req)) begin
            mWho    = (bus.ic_req && bus.dc_req) ? !mLastDc : bus.dc_req;
            mLastDc = mWho;
            mBusy   = 1'b1;
            mG      = cyc;
            mWe     = mWho && bus.dc_we;
            mAddr   = mWho ? bus.dc_addr : bus.ic_addr;
            if (mWe) begin
               mWdata = bus.dc_wdata;
               modelRam[mAddr[7:0]] = mWdata;
            end else begin
               mData = modelRam[mAddr[7:0]];
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      idleInputs();
   endtask
endmodule
